// File: rtl/sparc_mul_arb_cntl.sv
// Multiplier issue arbiter and accumulator control. Issue and acks are combinational; done fires 5 cycles after issue.
// Requests are levels held until acked; SPU acc/byp hazards and busy ACCUM stall SPU ops or shift/clear commands.
module sparc_mul_arb_cntl (
  input  logic rclk,
  input  logic rst_l,
  input  logic ecl_mul_req_vld,
  input  logic spu_mul_req_vld,
  input  logic spu_mul_acc,
  input  logic spu_mul_byp,
  input  logic spu_mul_x2,
  input  logic spu_mul_areg_shf,
  input  logic spu_mul_areg_rst,
  output logic mul_ecl_ack,
  output logic mul_spu_ack,
  output logic mul_spu_acc_ack,
  output logic mul_ecl_done,
  output logic mul_spu_done,
  output logic valid,
  output logic spick,
  output logic byp_sel,
  output logic byp_imm,
  output logic x2,
  output logic acc_imm,
  output logic acc_actc3,
  output logic acc_reg_enb,
  output logic acc_reg_rst,
  output logic acc_reg_shf
);

  typedef struct packed {
    logic vld;
    logic spu;
    logic acc;
  } stg_t;

  // stg[k-1] is stage Sk: the op issued k cycles ago
  stg_t stg [5];
  logic last_spu;

  logic [4:0] acc_in;
  logic       acc_any14;
  logic       acc_any15;
  logic       spu_elig;
  logic       ecl_go;
  logic       spu_go;
  logic       acc_free;
  logic       rst_go;
  logic       shf_go;

  always_comb begin
    for (int k = 0; k < 5; k++) begin
      acc_in[k] = stg[k].vld & stg[k].acc;
    end
    acc_any14 = |acc_in[3:0];
    acc_any15 = |acc_in;
    spu_elig  = spu_mul_req_vld
              & ~(spu_mul_acc & acc_in[0])
              & ~(spu_mul_byp & acc_any14);
    // Round-robin: EXU wins a conflict when SPU was granted last
    ecl_go    = ecl_mul_req_vld & (~spu_elig | last_spu);
    spu_go    = spu_elig & ~ecl_go;
    acc_free  = ~acc_any15 & ~spu_go;
    rst_go    = acc_free & spu_mul_areg_rst;
    shf_go    = acc_free & spu_mul_areg_shf & ~spu_mul_areg_rst;
  end

  always_comb begin
    mul_ecl_ack     = 1'b0;
    mul_spu_ack     = 1'b0;
    mul_spu_acc_ack = 1'b0;
    mul_ecl_done    = 1'b0;
    mul_spu_done    = 1'b0;
    valid           = 1'b0;
    spick           = 1'b0;
    byp_sel         = 1'b0;
    byp_imm         = 1'b0;
    x2              = 1'b0;
    acc_imm         = 1'b0;
    acc_actc3       = 1'b0;
    acc_reg_enb     = 1'b0;
    acc_reg_rst     = 1'b0;
    acc_reg_shf     = 1'b0;
    if (rst_l) begin
      mul_ecl_ack     = ecl_go;
      mul_spu_ack     = spu_go;
      mul_spu_acc_ack = rst_go | shf_go;
      mul_ecl_done    = stg[4].vld & ~stg[4].spu;
      mul_spu_done    = stg[4].vld & stg[4].spu;
      valid           = ecl_go | spu_go;
      spick           = spu_go;
      byp_sel         = spu_go & spu_mul_byp;
      byp_imm         = spu_go & spu_mul_byp & acc_in[4];
      x2              = spu_go & spu_mul_x2;
      acc_imm         = acc_in[2] & acc_in[4];
      acc_actc3       = acc_in[2];
      acc_reg_enb     = acc_in[4] | shf_go;
      acc_reg_rst     = rst_go;
      acc_reg_shf     = shf_go;
    end
  end

  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      for (int k = 0; k < 5; k++) begin
        stg[k] <= '0;
      end
      last_spu <= 1'b1;
    end else begin
      stg[0] <= '{vld: ecl_go | spu_go, spu: spu_go, acc: spu_go & spu_mul_acc};
      for (int k = 1; k < 5; k++) begin
        stg[k] <= stg[k-1];
      end
      if (ecl_go | spu_go) begin
        last_spu <= spu_go;
      end
    end
  end

endmodule

// File: doc/sparc_mul_arb_cntl.md
SPARC_MUL_ARB_CNTL -- requirements
Module: sparc_mul_arb_cntl

Interface
REQ-001 SHALL have port rclk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_l, input, 1: reset, synchronous, active-low.
REQ-003 SHALL have port ecl_mul_req_vld, input, 1: EXU multiply request; level, held until mul_ecl_ack.
REQ-004 SHALL have port spu_mul_req_vld, input, 1: SPU multiply request; level, held until mul_spu_ack.
REQ-005 SHALL have port spu_mul_acc, input, 1: SPU op accumulates into ACCUM; qualified by spu_mul_req_vld.
REQ-006 SHALL have port spu_mul_byp, input, 1: SPU op takes op2 from ACCUM[63:0]; qualified by spu_mul_req_vld.
REQ-007 SHALL have port spu_mul_x2, input, 1: SPU op result doubled; qualified by spu_mul_req_vld.
REQ-008 SHALL have port spu_mul_areg_shf, input, 1: ACCUM shift-right-64 request; level, held until mul_spu_acc_ack.
REQ-009 SHALL have port spu_mul_areg_rst, input, 1: ACCUM clear request; level, held until mul_spu_acc_ack.
REQ-010 SHALL have ports mul_ecl_ack and mul_spu_ack, output, 1 each: request granted this cycle.
REQ-011 SHALL have port mul_spu_acc_ack, output, 1: shift/clear command granted this cycle.
REQ-012 SHALL have ports mul_ecl_done and mul_spu_done, output, 1 each: owner's result on mout this cycle.
REQ-013 SHALL have ports valid, spick, byp_sel, byp_imm, x2, output, 1 each: datapath issue controls.
REQ-014 SHALL have ports acc_imm, acc_actc3, acc_reg_enb, acc_reg_rst, acc_reg_shf, output, 1 each: datapath accumulate controls.

Function
REQ-015 SHALL track in-flight ops in stages S1..S5; each stage holds {vld, spu, acc}; Sk is the op issued k cycles earlier; stages advance every cycle.
REQ-016 SHALL have a fixed latency of 5: an op issued in cycle N SHALL pulse mul_ecl_done or mul_spu_done (owner only) in cycle N+5.
REQ-017 SHALL allow at most one issue per cycle, with back-to-back issue permitted; issuing SHALL assert valid=1, the ack, and spick=1 for SPU or 0 for EXU, all combinationally in the issue cycle.
REQ-018 SHALL, when an SPU op issues, drive x2=spu_mul_x2; x2 SHALL otherwise be 0.
REQ-019 SHALL arbitrate EXU and SPU when both are eligible by round-robin using a last-grant flop; after reset last-grant=SPU, so the EXU wins the first conflict.
REQ-020 SHALL make an SPU op with spu_mul_acc=1 ineligible while S1 holds an acc op.
REQ-021 SHALL make an SPU op with spu_mul_byp=1 ineligible while any of S1..S4 holds an acc op.
REQ-022 SHALL NOT let an ineligible SPU request block the EXU or update last-grant.
REQ-023 SHALL, for an eligible byp op, drive byp_sel=1, and drive byp_imm=1 iff S5 holds an acc op; both SHALL be 0 otherwise.
REQ-024 SHALL drive acc_actc3=1 iff S3 holds an acc op.
REQ-025 SHALL drive acc_imm=1 iff S3 and S5 both hold acc ops.
REQ-026 SHALL drive acc_reg_enb=1 in the cycle S5 holds an acc op, loading mout into ACCUM.
REQ-027 SHALL grant a shift/clear command only when S1..S5 hold no acc op and no SPU op issues this cycle.
REQ-028 SHALL, when shift and clear are both requested, grant clear first.
REQ-029 SHALL, on a clear grant, drive acc_reg_rst=1 and mul_spu_acc_ack=1.
REQ-030 SHALL, on a shift grant, drive acc_reg_shf=1, acc_reg_enb=1 and mul_spu_acc_ack=1.
REQ-031 SHALL tie acc_reg_enb to the acc writeback only when no shift is granted; the two are mutually exclusive by REQ-027.
REQ-032 SHALL drive a non-granted command's controls to 0.

Reset
REQ-033 SHALL, on rst_l=0 at a clock edge, clear all stages and set last-grant=SPU.
REQ-034 SHALL force every output to 0 while rst_l=0, including mid-operation.
REQ-035 SHALL pulse no done for any op issued before reset.

Verification
REQ-036 SHALL cover: EXU req at cycle 0, idle otherwise -> valid=1, spick=0, mul_ecl_ack=1 at cycle 0; mul_ecl_done=1 at cycle 5 only.
REQ-037 SHALL cover: EXU and SPU both requesting continuously from reset -> grants alternate E,S,E,S; done pulses alternate from cycle 5.
REQ-038 SHALL cover: SPU acc ops requested every cycle -> issues at cycles 0,2,4; acc_imm=1 at cycles 5 and 7; acc_reg_enb=1 at cycles 5,7,9.
REQ-039 SHALL cover: SPU acc op at cycle 0, byp op requested at cycle 1 -> stalled through cycle 4, issues at cycle 5 with byp_sel=1, byp_imm=1.
REQ-040 SHALL cover: shift requested at cycle 1 after acc op at cycle 0 -> ack at cycle 6 with acc_reg_shf=1, acc_reg_enb=1; clear+shift together -> clear first, shift next cycle.
REQ-041 SHALL cover: rst_l=0 at cycle 3 with 3 ops in flight -> all outputs 0; no done pulse at cycles 4..8.
